// File: rtl/jtopl_exp_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtopl_exp_pipe_pkg
//  Description : Shared exponent-table constants for the log-to-linear path.
//                EXP[i] = round(1024 * 2^((255-i)/256)) - 1024, 256 x 10 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtopl_exp_pipe_pkg;

  localparam int EXP_MANT_W = 11;   // {hidden 1, 10-bit table entry}
  localparam int MAX_SHIFT  = 10;   // larger shifts always flush to zero
  localparam int EXP_DEPTH  = 256;
  localparam int EXP_W      = 10;

  // 2^(1/256) in Q30, the per-entry growth factor of the table
  localparam logic [63:0] C_STEP_Q30 = 64'd1076653033;

  // Builds the whole table at elaboration time so every consumer shares one
  // definition and no hand-typed constant list can drift out of sync.
  function automatic logic [EXP_DEPTH*EXP_W-1:0] exp_rom_build();
    logic [EXP_DEPTH*EXP_W-1:0] rom;
    logic [63:0]                v;
    logic [63:0]                m;
    rom = '0;
    v   = 64'd1 << 30;
    for (int j = 0; j < EXP_DEPTH; j++) begin
      // m = round(1024 * 2^(j/256)), always within [1024, 2047]
      m = ((v << 10) + (64'd1 << 29)) >> 30;
      // dropping bit 10 removes the hidden 1024
      rom[(EXP_DEPTH-1-j)*EXP_W +: EXP_W] = m[EXP_W-1:0];
      v = (v * C_STEP_Q30) >> 30;
    end
    return rom;
  endfunction

  localparam logic [EXP_DEPTH*EXP_W-1:0] EXP_ROM = exp_rom_build();

endpackage
`default_nettype wire

// File: rtl/jtopl_exp_acc.sv
`default_nettype none
// ============================================================================
//  Module      : jtopl_exp_acc
//  Description : Saturating per-frame accumulator with a one-edge frame-done
//                strobe. The sum is clamped on every addition, so a saturated
//                running value can still be pulled back by later samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtopl_exp_acc #(
  parameter int OUT_W = 14,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cen,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [OUT_W-1:0] i_data,
  output logic             o_acc_valid,
  output logic [ACC_W-1:0] o_acc
);

  // one guard bit above the wider operand keeps the raw sum exact
  localparam int SUM_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'((64'd1 << (ACC_W-1)) - 64'd1);
  localparam logic signed [SUM_W-1:0] C_MIN = ~C_MAX;

  logic        [ACC_W-1:0] r_acc;
  logic signed [SUM_W-1:0] w_acc_ext;
  logic signed [SUM_W-1:0] w_in_ext;
  logic signed [SUM_W-1:0] w_sum;
  logic        [ACC_W-1:0] w_sat;

  assign w_acc_ext = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_in_ext  = {{(SUM_W-OUT_W){i_data[OUT_W-1]}}, i_data};
  assign w_sum     = w_acc_ext + w_in_ext;

  // clamp the exact sum into the signed accumulator range
  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum > C_MAX)      w_sat = C_MAX[ACC_W-1:0];
    else if (w_sum < C_MIN) w_sat = C_MIN[ACC_W-1:0];
  end

  // running sum, frame result and frame-done strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      o_acc       <= '0;
      o_acc_valid <= 1'b0;
    end else if (i_cen) begin
      if (i_valid && i_last) begin
        o_acc       <= w_sat;
        o_acc_valid <= 1'b1;
        r_acc       <= '0;
      end else begin
        if (i_valid) r_acc <= w_sat;
        o_acc_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtopl_exp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : jtopl_exp_pipe
//  Description : Log-to-linear converter: exponent table read, right shift by
//                the integer attenuation, sign application, plus an optional
//                saturating frame accumulator. Three-stage, cen-qualified,
//                tag carried alongside every sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtopl_exp_pipe
  import jtopl_exp_pipe_pkg::*;
#(
  parameter int SH_W   = 4,
  parameter int OUT_W  = 14,
  parameter int TAG_W  = 5,
  parameter bit ACC_EN = 1'b1,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cen,
  input  logic              i_valid,
  input  logic [SH_W+7:0]   i_att,
  input  logic              i_sign,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_last,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_lin,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_acc_valid,
  output logic [ACC_W-1:0]  o_acc
);

  logic [EXP_W-1:0] w_rom [EXP_DEPTH];

  for (genvar k = 0; k < EXP_DEPTH; k++) begin : g_rom
    assign w_rom[k] = EXP_ROM[k*EXP_W +: EXP_W];
  end

  // S1 state
  logic [EXP_MANT_W-1:0] r_s1_mant;
  logic [SH_W-1:0]       r_s1_sh;
  logic                  r_s1_sign, r_s1_last, r_s1_valid;
  logic [TAG_W-1:0]      r_s1_tag;
  // S2 state
  logic [EXP_MANT_W-1:0] r_s2_lin;
  logic                  r_s2_sign, r_s2_last, r_s2_valid;
  logic [TAG_W-1:0]      r_s2_tag;
  // S3 side band for the accumulator
  logic                  r_s3_last;

  logic [EXP_MANT_W-1:0] w_s2_lin;
  logic [OUT_W-1:0]      w_s3_ext;
  logic [OUT_W-1:0]      w_s3_val;

  assign w_s2_lin = (int'(r_s1_sh) > MAX_SHIFT) ? '0 : (r_s1_mant >> r_s1_sh);
  assign w_s3_ext = {{(OUT_W-EXP_MANT_W){1'b0}}, r_s2_lin};
  assign w_s3_val = r_s2_sign ? (-w_s3_ext) : w_s3_ext;

  // S1: synchronous table read with cen as read enable; side band registered alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_mant  <= '0;
      r_s1_sh    <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_last  <= 1'b0;
      r_s1_valid <= 1'b0;
    end else if (i_cen) begin
      r_s1_mant  <= {1'b1, w_rom[i_att[7:0]]};
      r_s1_sh    <= i_att[SH_W+7:8];
      r_s1_sign  <= i_sign;
      r_s1_tag   <= i_tag;
      r_s1_last  <= i_last & i_valid;   // a last flag on a bubble carries no meaning
      r_s1_valid <= i_valid;
    end
  end

  // S2: logical right shift by the integer attenuation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_lin   <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_last  <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (i_cen) begin
      r_s2_lin   <= w_s2_lin;
      r_s2_sign  <= r_s1_sign;
      r_s2_tag   <= r_s1_tag;
      r_s2_last  <= r_s1_last;
      r_s2_valid <= r_s1_valid;
    end
  end

  // S3: two's complement sign application onto the output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_lin     <= '0;
      o_tag     <= '0;
      o_valid   <= 1'b0;
      r_s3_last <= 1'b0;
    end else if (i_cen) begin
      o_lin     <= w_s3_val;
      o_tag     <= r_s2_tag;
      o_valid   <= r_s2_valid;
      r_s3_last <= r_s2_last;
    end
  end

  if (ACC_EN) begin : g_acc
    jtopl_exp_acc #(
      .OUT_W (OUT_W),
      .ACC_W (ACC_W)
    ) u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cen       (i_cen),
      .i_valid     (o_valid),
      .i_last      (r_s3_last),
      .i_data      (o_lin),
      .o_acc_valid (o_acc_valid),
      .o_acc       (o_acc)
    );
  end else begin : g_no_acc
    assign o_acc_valid = 1'b0;
    assign o_acc       = '0;
  end

endmodule
`default_nettype wire
